// File: rtl/exu_mpregfile_pkg.sv
// Shared sizing defaults for the EXU multi-port register file and its
// scoreboard, plus a packed-slice helper for the flattened port buses.
`ifndef EXU_MPREGFILE_PKG_SV
`define EXU_MPREGFILE_PKG_SV

// Slice i of a packed bus built from equal-width fields of width w.
`define E203_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package exu_mpregfile_pkg;

  localparam int E203_XLEN        = 32;  // data width
  localparam int E203_RFIDX_WIDTH = 5;   // register index width
  localparam int E203_RFREG_NUM   = 32;  // implemented registers (16 for RV32E)
  localparam int E203_RF_NRD      = 2;   // read ports, 1..4
  localparam int E203_RF_NWR      = 2;   // write ports, 1..3

endpackage

`endif

// File: rtl/exu_rf_scoreboard.sv
// Pending-bit scoreboard for the register file. One bit per register, set
// by dispatch when a long-latency op is allocated, cleared by the retiring
// writeback. x0 never goes pending. pend_nxt exposes the value being loaded
// this cycle so a bypassing read can report the post-update state.
module exu_rf_scoreboard
  import exu_mpregfile_pkg::*;
#(
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int NREG    = E203_RFREG_NUM,
  parameter int NWR     = E203_RF_NWR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_en,
  input  logic [RFIDX_W-1:0]     alloc_idx,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*RFIDX_W-1:0] wr_idx,
  input  logic [NWR-1:0]         wr_clr,
  output logic [NREG-1:0]        pend_vec,
  output logic [NREG-1:0]        pend_nxt
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Next pending state: clear on a retiring write, then allocate on top so
  // the younger op wins when both hit the same register.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier ones; the ordering below encodes the alloc-over-clear priority.
    pend_d    = pend_q;
    pend_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_clr[w] &&
            (`E203_SLICE(wr_idx, w, RFIDX_W) == RFIDX_W'(r))) begin
          pend_d[r] = 1'b0;
        end
      end
      if (alloc_en && (alloc_idx == RFIDX_W'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
  end

  // Pending flops; an asserted reset drops all outstanding state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;
  assign pend_nxt = pend_d;

endmodule

// File: rtl/exu_mpregfile.sv
// EXU multi-port integer register file with per-register pending bits.
// Reads are combinational; writes land on the rising clock edge, highest
// write port winning a collision. x0 and indices >= NREG read as zero and
// ignore writes/allocates.
// Optional feature: define E203_REGFILE_BYPASS_EN to forward same-cycle
// write data (and the post-update pending bit) straight to the read ports.
module exu_mpregfile
  import exu_mpregfile_pkg::*;
#(
  parameter int XLEN    = E203_XLEN,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int NREG    = E203_RFREG_NUM,
  parameter int NRD     = E203_RF_NRD,
  parameter int NWR     = E203_RF_NWR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   test_mode,
  input  logic [NRD*RFIDX_W-1:0] rd_idx,
  output logic [NRD*XLEN-1:0]    rd_dat,
  output logic [NRD-1:0]         rd_pend,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*RFIDX_W-1:0] wr_idx,
  input  logic [NWR*XLEN-1:0]    wr_dat,
  input  logic [NWR-1:0]         wr_clr,
  input  logic                   alloc_en,
  input  logic [RFIDX_W-1:0]     alloc_idx,
  output logic [NREG-1:0]        pend_vec,
  output logic [XLEN-1:0]        x1_r
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] pend_nxt;

  // DFT input has no functional use inside the register file.
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  exu_rf_scoreboard #(
    .RFIDX_W (RFIDX_W),
    .NREG    (NREG),
    .NWR     (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (alloc_en),
    .alloc_idx (alloc_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_clr    (wr_clr),
    .pend_vec  (pend_vec),
    .pend_nxt  (pend_nxt)
  );

  // Write select: later ports overwrite earlier ones, so the highest
  // enabled port targeting a register supplies its data.
  always_comb begin
    rf_d    = rf_q;
    rf_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (`E203_SLICE(wr_idx, w, RFIDX_W) == RFIDX_W'(r))) begin
          rf_d[r] = `E203_SLICE(wr_dat, w, XLEN);
        end
      end
    end
  end

  // Data array; x0 is held at zero by the write select above.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset on purpose -- architectural registers must
    // read 0 after reset, so this is not left as an unreset RAM.
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read mux: only indices 1..NREG-1 select a register; everything else
  // falls through to the zero default.
  always_comb begin
    rd_dat  = '0;
    rd_pend = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (`E203_SLICE(rd_idx, p, RFIDX_W) == RFIDX_W'(r)) begin
          `E203_SLICE(rd_dat, p, XLEN) = rf_q[r];
          rd_pend[p]                   = pend_vec[r];
`ifdef E203_REGFILE_BYPASS_EN
          for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (`E203_SLICE(wr_idx, w, RFIDX_W) == RFIDX_W'(r))) begin
              `E203_SLICE(rd_dat, p, XLEN) = `E203_SLICE(wr_dat, w, XLEN);
              rd_pend[p]                   = pend_nxt[r];
            end
          end
`endif
        end
      end
    end
  end

`ifndef E203_REGFILE_BYPASS_EN
  // Without forwarding the next-state pending vector has no reader here.
  logic unused_pend_nxt;
  assign unused_pend_nxt = ^pend_nxt;
`endif

  assign x1_r = rf_q[1];

endmodule

// File: tb/tb_exu_mpregfile.sv
// Self-checking bench for exu_mpregfile: directed steps from the test plan
// followed by random traffic, all checked against an array-based model.
module tb_exu_mpregfile;
  import exu_mpregfile_pkg::*;

  localparam int XLEN    = E203_XLEN;
  localparam int RFIDX_W = E203_RFIDX_WIDTH;
  localparam int NREG    = E203_RFREG_NUM;
  localparam int NRD     = E203_RF_NRD;
  localparam int NWR     = E203_RF_NWR;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   test_mode;
  logic [NRD*RFIDX_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]    rd_dat;
  logic [NRD-1:0]         rd_pend;
  logic [NWR-1:0]         wr_en;
  logic [NWR*RFIDX_W-1:0] wr_idx;
  logic [NWR*XLEN-1:0]    wr_dat;
  logic [NWR-1:0]         wr_clr;
  logic                   alloc_en;
  logic [RFIDX_W-1:0]     alloc_idx;
  logic [NREG-1:0]        pend_vec;
  logic [XLEN-1:0]        x1_r;

  exu_mpregfile #(
    .XLEN (XLEN), .RFIDX_W (RFIDX_W), .NREG (NREG), .NRD (NRD), .NWR (NWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .rd_idx    (rd_idx),
    .rd_dat    (rd_dat),
    .rd_pend   (rd_pend),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_dat    (wr_dat),
    .wr_clr    (wr_clr),
    .alloc_en  (alloc_en),
    .alloc_idx (alloc_idx),
    .pend_vec  (pend_vec),
    .x1_r      (x1_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural register values and pending flags.
  logic [XLEN-1:0] m_rf [NREG];
  logic [NREG-1:0] m_pend;

`ifdef E203_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit real_reg(input int idx);
    return (idx != 0) && (idx < NREG);
  endfunction

  function automatic int widx(input int w);
    return int'(wr_idx[w*RFIDX_W +: RFIDX_W]);
  endfunction

  // Pending value a register will hold after the coming edge.
  function automatic logic next_pend(input int idx);
    logic v;
    if (!real_reg(idx)) return 1'b0;
    v = m_pend[idx];
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_clr[w] && widx(w) == idx) v = 1'b0;
    if (alloc_en && int'(alloc_idx) == idx) v = 1'b1;
    return v;
  endfunction

  // Highest enabled write port aimed at idx, or -1.
  function automatic int last_writer(input int idx);
    int hit = -1;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && widx(w) == idx) hit = w;
    return hit;
  endfunction

  function automatic logic [XLEN-1:0] exp_dat(input int idx);
    int w;
    if (!real_reg(idx)) return '0;
    w = last_writer(idx);
    if (BYPASS && w >= 0) return wr_dat[w*XLEN +: XLEN];
    return m_rf[idx];
  endfunction

  function automatic logic exp_pend(input int idx);
    if (!real_reg(idx)) return 1'b0;
    if (BYPASS && last_writer(idx) >= 0) return next_pend(idx);
    return m_pend[idx];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_rf[r] = '0;
    m_pend = '0;
  endtask

  task automatic model_edge();
    logic [NREG-1:0] np;
    int w;
    for (int r = 0; r < NREG; r++) np[r] = next_pend(r);
    for (int r = 1; r < NREG; r++) begin
      w = last_writer(r);
      if (w >= 0) m_rf[r] = wr_dat[w*XLEN +: XLEN];
    end
    m_pend = np;
  endtask

  task automatic check_all(input string tag);
    int idx;
    for (int p = 0; p < NRD; p++) begin
      idx = int'(rd_idx[p*RFIDX_W +: RFIDX_W]);
      check($sformatf("%s rd_dat%0d x%0d", tag, p, idx), 64'(rd_dat[p*XLEN +: XLEN]), 64'(exp_dat(idx)));
      check($sformatf("%s rd_pend%0d x%0d", tag, p, idx), 64'(rd_pend[p]), 64'(exp_pend(idx)));
    end
    check({tag, " pend_vec"}, 64'(pend_vec), 64'(m_pend));
    check({tag, " x1_r"}, 64'(x1_r), 64'(m_rf[1]));
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge,
  // and leave time 1 unit past the edge for the next stimulus.
  task automatic tick(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_idx = '0; wr_dat = '0; wr_clr = '0;
    alloc_en = 1'b0; alloc_idx = '0;
  endtask

  task automatic drive_wr(input int w, input int idx, input logic [XLEN-1:0] dat, input logic clr);
    wr_en[w] = 1'b1;
    wr_idx[w*RFIDX_W +: RFIDX_W] = RFIDX_W'(idx);
    wr_dat[w*XLEN +: XLEN] = dat;
    wr_clr[w] = clr;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_idx[p*RFIDX_W +: RFIDX_W] = RFIDX_W'(idx);
  endtask

  initial begin
    rst_n = 1'b0; test_mode = 1'b0; rd_idx = '0;
    idle_inputs();
    model_reset();
    set_rd(0, 1); set_rd(1, 5);
    #1;
    check("reset rd_dat", 64'(rd_dat), 64'(0));
    check("reset pend_vec", 64'(pend_vec), 64'(0));
    check("reset x1_r", 64'(x1_r), 64'(0));
    #6 rst_n = 1'b1;

    // Basic write of x5, visible next cycle.
    drive_wr(0, 5, 32'hDEADBEEF, 1'b0);
    tick("wr x5");
    idle_inputs(); set_rd(0, 5); #1;
    check("x5 readback", 64'(rd_dat[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);

    // x0 ignores writes; x1 shows on x1_r.
    drive_wr(0, 0, 32'h0000_1234, 1'b0);
    drive_wr(1, 1, 32'h8000_0004, 1'b0);
    tick("wr x0 x1");
    idle_inputs(); set_rd(0, 0); set_rd(1, 1); #1;
    check("x0 reads zero", 64'(rd_dat[0 +: XLEN]), 64'(0));
    check("x1_r", 64'(x1_r), 64'h0000_0000_8000_0004);

    // Collision: higher port wins.
    drive_wr(0, 7, 32'h11, 1'b0);
    drive_wr(1, 7, 32'h22, 1'b0);
    tick("collide x7");
    idle_inputs(); set_rd(1, 7); #1;
    check("x7 collision", 64'(rd_dat[XLEN +: XLEN]), 64'h22);

    // Scoreboard set / plain write / retiring write.
    alloc_en = 1'b1; alloc_idx = 9;
    tick("alloc x9");
    idle_inputs(); set_rd(0, 9); #1;
    check("x9 pend after alloc", 64'(rd_pend[0]), 64'(1));
    drive_wr(0, 9, 32'h55, 1'b0);
    tick("plain wr x9");
    idle_inputs(); #1;
    check("x9 pend after plain wr", 64'(pend_vec[9]), 64'(1));
    check("x9 data after plain wr", 64'(rd_dat[0 +: XLEN]), 64'h55);
    drive_wr(1, 9, 32'h66, 1'b1);
    tick("clr wr x9");
    idle_inputs(); #1;
    check("x9 pend after clr", 64'(rd_pend[0]), 64'(0));

    // Allocate beats clear; alloc on x0 is ignored.
    alloc_en = 1'b1; alloc_idx = 9;
    drive_wr(0, 9, 32'h77, 1'b1);
    tick("alloc+clr x9");
    idle_inputs(); #1;
    check("x9 alloc beats clr", 64'(pend_vec[9]), 64'(1));
    alloc_en = 1'b1; alloc_idx = 0;
    tick("alloc x0");
    idle_inputs(); set_rd(0, 0); #1;
    check("x0 never pending", 64'(pend_vec[0]), 64'(0));
    check("x0 rd_pend", 64'(rd_pend[0]), 64'(0));

    // Same-cycle write/read of x3: forwarded only with the bypass build.
    drive_wr(0, 3, 32'hA5A5A5A5, 1'b0);
    set_rd(0, 3); #1;
    check("x3 same cycle", 64'(rd_dat[0 +: XLEN]), BYPASS ? 64'hA5A5A5A5 : 64'(0));
    tick("wr x3");
    idle_inputs(); #1;
    check("x3 next cycle", 64'(rd_dat[0 +: XLEN]), 64'hA5A5A5A5);

    // Same-cycle retiring write of pending x9 seen on the read port.
    drive_wr(1, 9, 32'h99, 1'b1);
    set_rd(1, 9); #1;
    check("x9 pend same cycle", 64'(rd_pend[1]), BYPASS ? 64'(0) : 64'(1));
    tick("clr x9 bypass");
    idle_inputs();

    // Reset in the middle of traffic clears everything immediately.
    alloc_en = 1'b1; alloc_idx = 12;
    drive_wr(0, 5, 32'hCAFE0000, 1'b0);
    set_rd(0, 5); set_rd(1, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid reset pend_vec", 64'(pend_vec), 64'(0));
    check("mid reset rd_dat", 64'(rd_dat), 64'(0));
    check("mid reset x1_r", 64'(x1_r), 64'(0));
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1; #1;
    check("x5 after reset", 64'(rd_dat[0 +: XLEN]), 64'(0));
    tick("post reset");

    // Random traffic, indices biased low so collisions and alloc/clear
    // overlaps happen often.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 11));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]  = 1'($urandom_range(0, 1));
        wr_idx[w*RFIDX_W +: RFIDX_W] = RFIDX_W'($urandom_range(0, 11));
        wr_dat[w*XLEN +: XLEN] = XLEN'($urandom);
        wr_clr[w] = 1'($urandom_range(0, 1));
      end
      alloc_en  = ($urandom_range(0, 2) == 0);
      alloc_idx = RFIDX_W'($urandom_range(0, 11));
      tick($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
